// File: rtl/frac_lut_pkg.sv
// frac_lut_pkg: shared FSM state type and sizing helpers for the LUT tile.
// FRAC_LUT_CFG_PARITY_EN appends an even-parity bit to the config chain.
package frac_lut_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    SHIFT = 2'd1,
    CFGD  = 2'd2
  } cfg_state_t;

`ifdef FRAC_LUT_CFG_PARITY_EN
  localparam int CFG_PAR = 1;
`else
  localparam int CFG_PAR = 0;
`endif

  function automatic int cfg_len(
    input int k,
    input int mode_bits,
    input int parity
  );
    return (1 << k) + mode_bits + parity;
  endfunction

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  // counter width of the default K=6, MODE_BITS=1 tile
  localparam int CNT_W_DEF = cnt_width(cfg_len(6, 1, CFG_PAR));

endpackage

// File: rtl/frac_lut_cfg_chain.sv
// frac_lut_cfg_chain: serial config chain, shift counter, load FSM.
// FRAC_LUT_CFG_PARITY_EN adds the running parity check and cfg_err.
module frac_lut_cfg_chain
  import frac_lut_pkg::*;
#(
  parameter int K         = 6,
  parameter int MODE_BITS = 1,
  parameter int CFG_LEN   = cfg_len(K, MODE_BITS, CFG_PAR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en,
  input  logic               ccff_head,
  output logic [CFG_LEN-1:0] chain,
  output logic               ccff_tail,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam int CNT_W = cnt_width(CFG_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_LEN - 1);

  cfg_state_t       state;
  cfg_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             enter_shift;
  logic             enter_cfgd;

  // this edge shifts the final bit of the load
  assign last_bit    = (state == SHIFT) && (cnt == LAST);
  assign enter_shift = cfg_en && (state != SHIFT);
  assign enter_cfgd  = cfg_en && last_bit;
  assign ccff_tail   = chain[CFG_LEN-1];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNCFG;
    else        state <= state_nxt;
  end

  // next-state: cfg_en low pauses everything
  always_comb begin
    state_nxt = state;
    if (cfg_en) begin
      case (state)
        UNCFG:   state_nxt = SHIFT;
        SHIFT:   if (last_bit) state_nxt = CFGD;
        CFGD:    state_nxt = SHIFT;
        default: state_nxt = UNCFG;
      endcase
    end
  end

  // state outputs
  always_comb begin
    cfg_done = (state == CFGD);
  end

  // config shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chain <= '0;
    else if (cfg_en) chain <= {chain[CFG_LEN-2:0], ccff_head};
  end

  // shift counter, cleared on completion so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cfg_en) begin
      if (state != SHIFT) cnt <= CNT_W'(1);
      else if (last_bit)  cnt <= '0;
      else                cnt <= cnt + 1'b1;
    end
  end

`ifdef FRAC_LUT_CFG_PARITY_EN
  logic acc;

  // running xor of the load; the verdict latches on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (enter_shift) begin
        acc     <= ccff_head;
        cfg_err <= 1'b0;
      end else if (cfg_en) begin
        acc <= acc ^ ccff_head;
      end
      if (enter_cfgd) cfg_err <= acc ^ ccff_head;
    end
  end
`else
  logic flags_unused;
  assign flags_unused = enter_shift ^ enter_cfgd;
  assign cfg_err = 1'b0;
`endif

endmodule

// File: rtl/frac_lutk_cfg_tile.sv
// frac_lutk_cfg_tile: K-input LUT fracturable into 2^F LUT(K-F) outputs.
// FRAC_LUT_CFG_PARITY_EN: chain gains a trailing parity bit, gates on error.
module frac_lutk_cfg_tile
  import frac_lut_pkg::*;
#(
  parameter int K         = 6,
  parameter int F         = 1,
  parameter int MODE_BITS = 1
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                cfg_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [K-1:0]        lut_in,
  output logic                lut_k_out,
  output logic [(1<<F)-1:0]   lut_frac_out
);

  localparam int CFG_LEN = cfg_len(K, MODE_BITS, CFG_PAR);
  localparam int NSRAM   = 1 << K;
  localparam int SUB     = 1 << (K - F);
  localparam int NFRAC   = 1 << F;

  logic [CFG_LEN-1:0]   chain;
  logic [NSRAM-1:0]     sram;
  logic [MODE_BITS-1:0] mode;
  logic                 live;
  logic                 k_raw;
  logic [NFRAC-1:0]     frac_raw;
  logic                 mode_unused;

  frac_lut_cfg_chain #(
    .K         (K),
    .MODE_BITS (MODE_BITS),
    .CFG_LEN   (CFG_LEN)
  ) u_chain (
    .clk       (prog_clk),
    .rst_n     (pReset),
    .cfg_en    (cfg_en),
    .ccff_head (ccff_head),
    .chain     (chain),
    .ccff_tail (ccff_tail),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  // a parity bit, when present, sits below the truth table at chain[0]
  assign sram = chain[NSRAM-1+CFG_PAR : CFG_PAR];
  assign mode = chain[NSRAM+MODE_BITS-1+CFG_PAR : NSRAM+CFG_PAR];
  assign mode_unused = ^mode;

`ifdef FRAC_LUT_CFG_PARITY_EN
  logic par_unused;
  assign par_unused = chain[0];
`endif

  assign k_raw = sram[lut_in];

  for (genvar j = 0; j < NFRAC; j++) begin : g_frac
    logic [SUB-1:0] seg;
    assign seg         = sram[j*SUB +: SUB];
    assign frac_raw[j] = seg[lut_in[K-F-1:0]];
  end

  assign live = cfg_done & ~cfg_err;

  // mode select and gating until a clean configuration is in place
  always_comb begin
    lut_k_out    = live & ~mode[0] & k_raw;
    lut_frac_out = '0;
    if (live && mode[0]) lut_frac_out = frac_raw;
  end

endmodule
